// File: rtl/m_if_fetch.sv
// ---------------------------------------------------------------------------
// m_if_fetch
//
// Instruction-fetch front end. Owns the fetch PC, issues one outstanding
// request at a time to the instruction memory / MMU port, and holds a single
// fetched instruction in an output register for decode. Responses that
// belong to a fetch abandoned by a redirect or WFI are absorbed and dropped.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   csr_new_pc_req/pc  trap / xRET redirect (highest priority)
//   exe_new_pc_req/pc  branch / jump redirect
//   wfi_req, irq_wake  enter sleep / wake from sleep
//   id_stall           decode cannot take the held instruction this cycle
//   imem_*             request/grant/response handshake to instruction memory
//   i_page_fault_i     fault flag, qualified by imem_rvalid_i
//   if_valid_o, if_pc_o, if_instr_o, if_page_fault_o
//                      held instruction presented to decode
//   if_stall_o         fetch starved (no instruction held)
// ---------------------------------------------------------------------------
module m_if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_new_pc_req,
  input  logic [31:0] csr_new_pc,
  input  logic        exe_new_pc_req,
  input  logic [31:0] exe_new_pc,
  input  logic        wfi_req,
  input  logic        irq_wake,
  input  logic        id_stall,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        i_page_fault_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_page_fault_o,
  output logic        if_stall_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_SLEEP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_drop;
  logic        r_sleep_pend;

  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_pf;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_can_issue;
  logic        w_misaligned;
  logic        w_issue;

  assign w_redirect   = csr_new_pc_req | exe_new_pc_req;
  assign w_target     = csr_new_pc_req ? csr_new_pc : exe_new_pc;
  // The output register is guaranteed empty when a response lands because a
  // request is only issued when the held instruction can leave this cycle.
  assign w_can_issue  = ~r_if_valid | ~id_stall;
  assign w_misaligned = (r_pc[1:0] != 2'b00);

  assign imem_req_o   = (r_state == S_REQ) & w_can_issue & ~w_misaligned &
                        ~w_redirect & ~wfi_req & ~rst;
  assign imem_addr_o  = r_pc;
  assign w_issue      = imem_req_o & imem_gnt_i;

  assign if_valid_o      = r_if_valid;
  assign if_pc_o         = r_if_pc;
  assign if_instr_o      = r_if_instr;
  assign if_page_fault_o = r_if_pf;
  assign if_stall_o      = ~r_if_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_drop       <= 1'b0;
      r_sleep_pend <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= NOP_INSTR;
      r_if_pf      <= 1'b0;
    end else begin
      // Consumption by decode; any load below overrides this.
      if (r_if_valid && !id_stall) begin
        r_if_valid <= 1'b0;
      end

      if (w_redirect) begin
        r_pc         <= w_target;
        r_if_valid   <= 1'b0;
        r_sleep_pend <= 1'b0;
        case (r_state)
          S_WAIT: begin
            if (imem_rvalid_i) begin
              // Response arriving now is simply discarded.
              r_state <= S_REQ;
              r_drop  <= 1'b0;
            end else begin
              // Outstanding response still to come; absorb it later.
              r_drop  <= 1'b1;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end else if (wfi_req) begin
        r_if_valid <= 1'b0;
        case (r_state)
          S_REQ: r_state <= S_SLEEP;
          S_WAIT: begin
            if (imem_rvalid_i) begin
              r_state      <= S_SLEEP;
              r_drop       <= 1'b0;
              r_sleep_pend <= 1'b0;
            end else begin
              r_sleep_pend <= 1'b1;
              r_drop       <= 1'b1;
            end
          end
          S_SLEEP: r_state <= S_SLEEP;
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_can_issue && w_misaligned) begin
              // No memory access; hand decode a NOP tagged with the bad PC
              // so the exception logic downstream can raise and redirect.
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= NOP_INSTR;
              r_if_pf    <= 1'b0;
            end else if (w_issue) begin
              r_state  <= S_WAIT;
              r_req_pc <= r_pc;
              r_pc     <= r_pc + 32'd4;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (!r_drop) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
                r_if_pf    <= i_page_fault_i;
                r_if_instr <= i_page_fault_i ? NOP_INSTR : imem_rdata_i;
              end
              r_drop       <= 1'b0;
              r_sleep_pend <= 1'b0;
              r_state      <= r_sleep_pend ? S_SLEEP : S_REQ;
            end
          end
          S_SLEEP: begin
            if (irq_wake) begin
              r_state <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule
